// File: rtl/coproc_custom0_initiator.sv
// Core-side custom0 requester: issue -> request stream -> response stream -> writeback.
// Latency: best case 3 cycles from issue accept to wb_req_o, with one operation in flight.
// Backpressure: issue stalls while busy, the request is held until ack_i, writeback is held until wb_ack_i, and a timeout bounds the response wait.

package coproc_custom0_pkg;

  typedef struct packed {
    logic [31:0] instr_code;
    logic [31:0] src0_data;
    logic [31:0] src1_data;
  } req_struct;

  typedef struct packed {
    logic [31:0] data;
  } resp_struct;

  localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

endpackage

module coproc_custom0_initiator
  import coproc_custom0_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_req_i,
  input  logic [31:0] issue_instr_i,
  input  logic [31:0] issue_src0_i,
  input  logic [31:0] issue_src1_i,
  output logic        issue_ack_o,
  output logic        busy_o,
  output logic        illegal_o,
  output logic        stream_req_bus_genfifo_req_o,
  output req_struct   stream_req_bus_genfifo_wdata_bo,
  input  logic        stream_req_bus_genfifo_ack_i,
  input  logic        stream_resp_bus_genfifo_req_i,
  input  resp_struct  stream_resp_bus_genfifo_rdata_bi,
  output logic        stream_resp_bus_genfifo_ack_o,
  output logic        stray_resp_o,
  output logic        wb_req_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_err_o,
  input  logic        wb_ack_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    WB
  } state_t;

  state_t           state_q;
  state_t           state_d;
  state_t           done_state;
  logic [CNT_W-1:0] cnt_q;
  req_struct        req_q;
  logic [4:0]       rd_q;
  logic [31:0]      wb_data_q;
  logic             wb_err_q;
  logic             illegal_q;
  logic             stray_q;

  logic issue_ack;
  logic req_vld;
  logic resp_ack;
  logic wb_vld;
  logic accept_op;
  logic illegal_hit;
  logic stray_hit;
  logic resp_take;
  logic timeout_hit;
  logic timed_out;

  // x0 destinations have nothing to write back, so completion (normal or timeout) returns straight to IDLE
  assign done_state = (rd_q == 5'd0) ? IDLE : WB;
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; responses arriving in IDLE/WB are drained as strays
  always_comb begin
    state_d     = state_q;
    issue_ack   = 1'b0;
    req_vld     = 1'b0;
    resp_ack    = 1'b0;
    wb_vld      = 1'b0;
    accept_op   = 1'b0;
    illegal_hit = 1'b0;
    stray_hit   = 1'b0;
    resp_take   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        issue_ack = issue_req_i;
        resp_ack  = stream_resp_bus_genfifo_req_i;
        stray_hit = stream_resp_bus_genfifo_req_i;
        if (issue_req_i) begin
          if (issue_instr_i[6:0] == CUSTOM0_OPCODE) begin
            accept_op = 1'b1;
            state_d   = SEND;
          end else begin
            illegal_hit = 1'b1;
          end
        end
      end
      SEND: begin
        req_vld = 1'b1;
        if (stream_req_bus_genfifo_ack_i && stream_resp_bus_genfifo_req_i) begin
          resp_ack  = 1'b1;
          resp_take = 1'b1;
          state_d   = done_state;
        end else if (timed_out) begin
          timeout_hit = 1'b1;
          state_d     = done_state;
        end else if (stream_req_bus_genfifo_ack_i) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        resp_ack = stream_resp_bus_genfifo_req_i;
        if (stream_resp_bus_genfifo_req_i) begin
          resp_take = 1'b1;
          state_d   = done_state;
        end else if (timed_out) begin
          timeout_hit = 1'b1;
          state_d     = done_state;
        end
      end
      WB: begin
        wb_vld    = 1'b1;
        resp_ack  = stream_resp_bus_genfifo_req_i;
        stray_hit = stream_resp_bus_genfifo_req_i;
        if (wb_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // No handshakes complete while reset is held
    if (rst_i) begin
      issue_ack = 1'b0;
      resp_ack  = 1'b0;
    end
  end

  // Operation capture, timeout counter, writeback payload and one-cycle status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      req_q     <= '0;
      rd_q      <= 5'd0;
      wb_data_q <= 32'd0;
      wb_err_q  <= 1'b0;
      illegal_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      if (accept_op) begin
        req_q.instr_code <= issue_instr_i;
        req_q.src0_data  <= issue_src0_i;
        req_q.src1_data  <= issue_src1_i;
        rd_q             <= issue_instr_i[11:7];
        cnt_q            <= '0;
      end else if ((state_q == SEND) || (state_q == WAIT_RESP)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (resp_take) begin
        wb_data_q <= stream_resp_bus_genfifo_rdata_bi.data;
        wb_err_q  <= 1'b0;
      end else if (timeout_hit) begin
        wb_data_q <= 32'd0;
        wb_err_q  <= 1'b1;
      end
      illegal_q <= illegal_hit;
      stray_q   <= stray_hit;
    end
  end

  assign issue_ack_o                     = issue_ack;
  assign busy_o                          = (state_q != IDLE);
  assign illegal_o                       = illegal_q;
  assign stream_req_bus_genfifo_req_o    = req_vld;
  assign stream_req_bus_genfifo_wdata_bo = req_q;
  assign stream_resp_bus_genfifo_ack_o   = resp_ack;
  assign stray_resp_o                    = stray_q;
  assign wb_req_o                        = wb_vld;
  assign wb_rd_o                         = rd_q;
  assign wb_data_o                       = wb_data_q;
  assign wb_err_o                        = wb_err_q;

endmodule

// File: tb/tb_coproc_custom0_initiator.sv
// Bench for coproc_custom0_initiator: scenario tasks drive the issue/stream/writeback ports.
// Expected writebacks are queued when an op is issued and popped by a monitor on each wb handshake.
// Inputs change 1ns after posedge; outputs are sampled on negedge.

module tb_coproc_custom0_initiator;
  import coproc_custom0_pkg::*;

  localparam int TO = 16;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_req;
  logic [31:0] issue_instr;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        req_ack;
  logic        resp_req;
  resp_struct  resp_data;
  logic        wb_ack;

  logic        issue_ack_o;
  logic        busy_o;
  logic        illegal_o;
  logic        req_o;
  req_struct   wdata;
  logic        resp_ack_o;
  logic        stray_o;
  logic        wb_req_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_err_o;

  wire [140:0] all_out = {issue_ack_o, busy_o, illegal_o, req_o, wdata, resp_ack_o,
                          stray_o, wb_req_o, wb_rd_o, wb_data_o, wb_err_o};

  wb_t exp_q[$];
  wb_t got_wb;
  wb_t want_wb;
  int  pass_cnt  = 0;
  int  total_cnt = 0;
  int  xfer_cnt  = 0;

  logic [31:0] b2b_instr [0:2] = '{32'h0200038B, 32'h7E000F8B, 32'h0000040B};
  logic [31:0] b2b_resp  [0:2] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3};
  logic        b2b_comb  [0:2] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  coproc_custom0_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i                            (clk),
    .rst_i                            (rst),
    .issue_req_i                      (issue_req),
    .issue_instr_i                    (issue_instr),
    .issue_src0_i                     (src0),
    .issue_src1_i                     (src1),
    .issue_ack_o                      (issue_ack_o),
    .busy_o                           (busy_o),
    .illegal_o                        (illegal_o),
    .stream_req_bus_genfifo_req_o     (req_o),
    .stream_req_bus_genfifo_wdata_bo  (wdata),
    .stream_req_bus_genfifo_ack_i     (req_ack),
    .stream_resp_bus_genfifo_req_i    (resp_req),
    .stream_resp_bus_genfifo_rdata_bi (resp_data),
    .stream_resp_bus_genfifo_ack_o    (resp_ack_o),
    .stray_resp_o                     (stray_o),
    .wb_req_o                         (wb_req_o),
    .wb_rd_o                          (wb_rd_o),
    .wb_data_o                        (wb_data_o),
    .wb_err_o                         (wb_err_o),
    .wb_ack_i                         (wb_ack)
  );

  // Scoreboard: every writeback handshake must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && wb_req_o && wb_ack) begin
      got_wb = {wb_rd_o, wb_data_o, wb_err_o};
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_wb: got rd=%0d data=%h err=%b, required no writeback",
                 got_wb.rd, got_wb.data, got_wb.err);
      end else begin
        want_wb = exp_q.pop_front();
        if (got_wb !== want_wb)
          $display("FAIL sb_wb: got rd=%0d data=%h err=%b, required rd=%0d data=%h err=%b",
                   got_wb.rd, got_wb.data, got_wb.err, want_wb.rd, want_wb.data, want_wb.err);
        else
          pass_cnt++;
      end
    end
    if (!rst && req_o && req_ack) xfer_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_req = 1'b0; issue_instr = '0; src0 = '0; src1 = '0;
    req_ack = 1'b0; resp_req = 1'b0; resp_data = '0; wb_ack = 1'b1;
    step(); step(); settle();
    total_cnt++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h, required 0", all_out);
    else pass_cnt++;
    step(); rst = 1'b0;
  endtask

  task automatic test_basic(input logic [31:0] instr, input logic [31:0] s0,
                            input logic [31:0] s1, input logic [31:0] resp);
    step(); issue_req = 1'b1; issue_instr = instr; src0 = s0; src1 = s1;
    settle();
    total_cnt++;
    if ({issue_ack_o, busy_o} !== 2'b10) $display("FAIL basic_accept: got ack/busy=%b, required 10", {issue_ack_o, busy_o});
    else pass_cnt++;
    exp_q.push_back({instr[11:7], resp, 1'b0});
    step(); issue_req = 1'b0; req_ack = 1'b1;
    settle();
    total_cnt++;
    if ({req_o, busy_o} !== 2'b11) $display("FAIL basic_req: got req/busy=%b, required 11", {req_o, busy_o});
    else pass_cnt++;
    total_cnt++;
    if (wdata !== {instr, s0, s1}) $display("FAIL basic_wdata: got %h, required %h", wdata, {instr, s0, s1});
    else pass_cnt++;
    step(); req_ack = 1'b0; resp_req = 1'b1; resp_data = resp;
    settle();
    total_cnt++;
    if ({req_o, resp_ack_o} !== 2'b01) $display("FAIL basic_resp: got req/resp_ack=%b, required 01", {req_o, resp_ack_o});
    else pass_cnt++;
    step(); resp_req = 1'b0;
    settle();
    total_cnt++;
    if ({wb_req_o, wb_rd_o, wb_data_o, wb_err_o} !== {1'b1, instr[11:7], resp, 1'b0})
      $display("FAIL basic_wb_latency: got req=%b rd=%0d data=%h err=%b, required 1 %0d %h 0",
               wb_req_o, wb_rd_o, wb_data_o, wb_err_o, instr[11:7], resp);
    else pass_cnt++;
    step();
    settle();
    total_cnt++;
    if ({busy_o, wb_req_o} !== 2'b00) $display("FAIL basic_idle: got busy/wb_req=%b, required 00", {busy_o, wb_req_o});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int hi;
    int x0;
    hi = 0;
    step(); issue_req = 1'b1; issue_instr = 32'h0000048B; src0 = 32'hAAAA5555; src1 = 32'h0F0F0F0F;
    settle();
    total_cnt++;
    if (issue_ack_o !== 1'b1) $display("FAIL bp_accept: got %b, required 1", issue_ack_o);
    else pass_cnt++;
    exp_q.push_back({5'd9, 32'hCAFEF00D, 1'b0});
    step(); issue_req = 1'b0; x0 = xfer_cnt;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      req_ack = (k == 4);
      settle();
      if (req_o) hi++;
      total_cnt++;
      if (wdata !== {32'h0000048B, 32'hAAAA5555, 32'h0F0F0F0F})
        $display("FAIL bp_wdata_stable: cycle %0d got %h", k, wdata);
      else pass_cnt++;
    end
    step(); req_ack = 1'b0;
    settle();
    total_cnt++;
    if ({hi, req_o} !== {32'd5, 1'b0}) $display("FAIL bp_req_cycles: got %0d cycles, req now %b, required 5 and 0", hi, req_o);
    else pass_cnt++;
    total_cnt++;
    if (xfer_cnt - x0 !== 1) $display("FAIL bp_one_xfer: got %0d transfers, required 1", xfer_cnt - x0);
    else pass_cnt++;
    step(); resp_req = 1'b1; resp_data = 32'hCAFEF00D;
    settle();
    step(); resp_req = 1'b0;
    settle();
    total_cnt++;
    if (wb_req_o !== 1'b1) $display("FAIL bp_wb: got %b, required 1", wb_req_o);
    else pass_cnt++;
    step();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    step(); issue_req = 1'b1; issue_instr = 32'h0000030B; src0 = 32'd3; src1 = 32'd4;
    settle();
    exp_q.push_back({5'd6, 32'd0, 1'b1});
    step(); issue_req = 1'b0; req_ack = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      if (k > 1) step();
      settle();
      if (wb_req_o || !req_o) early++;
    end
    total_cnt++;
    if (early !== 0) $display("FAIL to_early: got %0d early/dropped cycles, required 0", early);
    else pass_cnt++;
    step();
    settle();
    total_cnt++;
    if ({wb_req_o, wb_err_o, wb_data_o, req_o} !== {1'b1, 1'b1, 32'd0, 1'b0})
      $display("FAIL to_wb: got req=%b err=%b data=%h sreq=%b, required 1 1 0 0", wb_req_o, wb_err_o, wb_data_o, req_o);
    else pass_cnt++;
    step(); step(); step(); resp_req = 1'b1; resp_data = 32'h0000DEAD;
    settle();
    total_cnt++;
    if (resp_ack_o !== 1'b1) $display("FAIL to_drain: got %b, required 1", resp_ack_o);
    else pass_cnt++;
    step(); resp_req = 1'b0;
    settle();
    total_cnt++;
    if ({stray_o, busy_o} !== 2'b10) $display("FAIL to_stray: got stray/busy=%b, required 10", {stray_o, busy_o});
    else pass_cnt++;
    step();
    settle();
    total_cnt++;
    if (stray_o !== 1'b0) $display("FAIL to_stray_pulse: got %b, required 0", stray_o);
    else pass_cnt++;
  endtask

  task automatic test_illegal_rd0();
    int x0;
    step(); issue_req = 1'b1; issue_instr = 32'h00B50533; src0 = 32'd1; src1 = 32'd1;
    settle();
    total_cnt++;
    if (issue_ack_o !== 1'b1) $display("FAIL ill_ack: got %b, required 1", issue_ack_o);
    else pass_cnt++;
    step(); issue_req = 1'b0; x0 = xfer_cnt;
    settle();
    total_cnt++;
    if ({illegal_o, req_o, busy_o} !== 3'b100) $display("FAIL ill_pulse: got ill/req/busy=%b, required 100", {illegal_o, req_o, busy_o});
    else pass_cnt++;
    step();
    settle();
    total_cnt++;
    if ({illegal_o, xfer_cnt - x0} !== {1'b0, 32'd0}) $display("FAIL ill_after: got ill=%b xfers=%0d, required 0 0", illegal_o, xfer_cnt - x0);
    else pass_cnt++;
    step(); issue_req = 1'b1; issue_instr = 32'h0A00000B; src0 = 32'd7; src1 = 32'd8;
    settle();
    step(); issue_req = 1'b0; req_ack = 1'b1; resp_req = 1'b1; resp_data = 32'h00000055;
    settle();
    total_cnt++;
    if ({req_o, resp_ack_o, wdata.instr_code} !== {2'b11, 32'h0A00000B})
      $display("FAIL rd0_req: got req=%b resp_ack=%b instr=%h, required 1 1 0a00000b", req_o, resp_ack_o, wdata.instr_code);
    else pass_cnt++;
    step(); req_ack = 1'b0; resp_req = 1'b0;
    settle();
    total_cnt++;
    if ({busy_o, wb_req_o, stray_o} !== 3'b000) $display("FAIL rd0_no_wb: got busy/wb/stray=%b, required 000", {busy_o, wb_req_o, stray_o});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step(); issue_req = 1'b1; issue_instr = b2b_instr[i]; src0 = i; src1 = i + 100;
      settle();
      total_cnt++;
      if (issue_ack_o !== 1'b1) $display("FAIL b2b_accept: op %0d got %b, required 1", i, issue_ack_o);
      else pass_cnt++;
      exp_q.push_back({b2b_instr[i][11:7], b2b_resp[i], 1'b0});
      step(); issue_req = 1'b0; req_ack = 1'b1; resp_req = b2b_comb[i]; resp_data = b2b_resp[i];
      settle();
      if (!b2b_comb[i]) begin
        step(); req_ack = 1'b0; resp_req = 1'b1;
        settle();
      end
      step(); req_ack = 1'b0; resp_req = 1'b0;
      settle();
      total_cnt++;
      if ({wb_req_o, wb_rd_o} !== {1'b1, b2b_instr[i][11:7]}) $display("FAIL b2b_wb: op %0d got req=%b rd=%0d", i, wb_req_o, wb_rd_o);
      else pass_cnt++;
    end
    step();
    settle();
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL b2b_idle: got %b, required 0", busy_o);
    else pass_cnt++;
  endtask

  task automatic test_wb_stall_reset();
    step(); issue_req = 1'b1; issue_instr = 32'h0600060B; src0 = 32'h11; src1 = 32'h22;
    settle();
    exp_q.push_back({5'd12, 32'h0BADBEEF, 1'b0});
    step(); issue_req = 1'b0; req_ack = 1'b1;
    settle();
    step(); req_ack = 1'b0; resp_req = 1'b1; resp_data = 32'h0BADBEEF; wb_ack = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      step(); resp_req = 1'b0; issue_req = 1'b1; issue_instr = 32'h0000068B; src0 = 32'h9; src1 = 32'h9;
      settle();
      total_cnt++;
      if ({wb_req_o, wb_rd_o, wb_data_o, wb_err_o, issue_ack_o} !== {1'b1, 5'd12, 32'h0BADBEEF, 1'b0, 1'b0})
        $display("FAIL stall_hold: cycle %0d got req=%b rd=%0d data=%h err=%b ack=%b", k, wb_req_o, wb_rd_o, wb_data_o, wb_err_o, issue_ack_o);
      else pass_cnt++;
    end
    step(); wb_ack = 1'b1;
    settle();
    total_cnt++;
    if (issue_ack_o !== 1'b0) $display("FAIL stall_ack_in_wb: got %b, required 0", issue_ack_o);
    else pass_cnt++;
    step();
    settle();
    total_cnt++;
    if (issue_ack_o !== 1'b1) $display("FAIL stall_next_accept: got %b, required 1", issue_ack_o);
    else pass_cnt++;
    step(); issue_req = 1'b0; req_ack = 1'b1;
    settle();
    step(); req_ack = 1'b0;
    settle();
    total_cnt++;
    if ({busy_o, req_o} !== 2'b10) $display("FAIL rst_wait_state: got busy/req=%b, required 10", {busy_o, req_o});
    else pass_cnt++;
    step(); rst = 1'b1;
    settle();
    step(); rst = 1'b0;
    settle();
    total_cnt++;
    if (all_out !== '0) $display("FAIL rst_outputs: got %h, required 0", all_out);
    else pass_cnt++;
    test_basic(32'h0000070B, 32'h33, 32'h44, 32'h600DF00D);
  endtask

  initial begin
    test_reset();
    test_basic(32'h0000028B, 32'h1, 32'h2, 32'h12345678);
    test_backpressure();
    test_timeout();
    test_illegal_rd0();
    test_back_to_back();
    test_wb_stall_reset();
    step();
    settle();
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d pending writebacks, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
